traffic_light_n: RTL and testbench
==================================

TRAFFIC_LIGHT_N -- requirements
Module: traffic_light_n

Interface
REQ-001 SHALL have parameter N_WAYS, default 4, number of approaches (2..8).
REQ-002 SHALL have parameter GREEN_T, default 10, green duration in ticks (1..99).
REQ-003 SHALL have parameter YELLOW_T, default 3, yellow duration in ticks (1..99).
REQ-004 SHALL have parameter ALLRED_T, default 1, all-red clearance in ticks (1..99).
REQ-005 SHALL have parameter EXT_T, default 5, green extension length in ticks (1..99).
REQ-006 SHALL have parameter MAX_EXT, default 2, maximum extensions per green (0..15).
REQ-007 SHALL have parameter SKIP_EMPTY, default 1, skip approaches with no traffic when set.
REQ-008 SHALL have ports: CLK in 1 clock; R in 1 reset, synchronous, active-high; tick in 1 one-second strobe; traffic in N_WAYS vehicle-present sensors; force in N_WAYS manual green request; green out N_WAYS; yellow out N_WAYS; red out N_WAYS; way out 3 index of served approach; bcd_tens out 4; bcd_ones out 4; blank out 1 display off.
REQ-009 SHALL use the single clock CLK; R SHALL be synchronous and active-high.

Function
REQ-010 SHALL implement states ALLRED, GREEN, YELLOW, MANUAL; all outputs registered.
REQ-011 SHALL keep a two-digit BCD down-counter rem; each phase entry loads its duration; a tick with rem>1 decrements it (BCD borrow 10->09); a tick with rem==1 ends the phase on that edge, so a phase lasts exactly its duration in ticks.
REQ-012 ALLRED end SHALL enter GREEN for way=nxt; GREEN end SHALL enter YELLOW for same way; YELLOW end SHALL enter ALLRED with nxt=way+1 mod N_WAYS, subject to REQ-013.
REQ-013 With SKIP_EMPTY=1 and any traffic bit set, nxt SHALL be the first way at or after the nominal nxt (round-robin) with traffic set, sampled at ALLRED end; with no traffic anywhere, the nominal nxt SHALL be used.
REQ-014 At GREEN end, if traffic[way]=1, no other traffic bit set and extension count<MAX_EXT, SHALL stay in GREEN, reload rem=EXT_T and increment the count; count SHALL clear on GREEN entry.
REQ-015 In GREEN: green[way]=1, others red; in YELLOW: yellow[way]=1, others red; in ALLRED: red all ones; exactly one of green/yellow/red SHALL be set per way in every cycle.
REQ-016 bcd_tens/bcd_ones SHALL show rem in GREEN and YELLOW with blank=0; in ALLRED and MANUAL blank=1 and digits=0.
REQ-017 force one-hot in any state SHALL enter MANUAL on the next edge: green on forced way, others red, way=forced index, tick ignored.
REQ-018 force zero or with multiple bits set SHALL not enter MANUAL; while in MANUAL, such force values SHALL exit to ALLRED (rem=ALLRED_T) with nxt=forced index+1 mod N_WAYS.
REQ-019 A change of one-hot force in MANUAL SHALL switch the green to the new way on the next edge without an ALLRED.
REQ-020 tick and phase end on the same edge as a valid force SHALL be overridden by force.
REQ-021 tick held high for multiple cycles SHALL count once per cycle; no edge detection is performed.

Reset
REQ-022 R=1 at a CLK edge SHALL set state=ALLRED, rem=ALLRED_T, nxt=0, way=0, extension count=0, green=0, yellow=0, red all ones, blank=1, digits=0, overriding tick and force, including mid-phase and in MANUAL.
REQ-023 The first tick after R falls SHALL count toward the ALLRED clearance.

Verification (defaults, N_WAYS=4)
REQ-024 Reset, traffic=4'b1111, 1 tick per 5 cycles -> ALLRED 1 tick, green[0] with display 10..01, yellow[0] 03..01, ALLRED, green[1]; full cycle 4x14 ticks.
REQ-025 traffic=4'b0001 held -> way 0 green 10 ticks then two extensions of 05 (display reloads 05), yellow after 20 ticks total, next green again way 0.
REQ-026 traffic=4'b1000 during way 0 yellow -> next green way 3, ways 1 and 2 skipped; traffic=0 -> plain round-robin 0,1,2,3.
REQ-027 force=4'b0100 mid-green of way 0 -> next edge green[2]=1, blank=1; force=4'b1100 -> ALLRED, then green way 3 with display 10.
REQ-028 R pulsed 1 cycle during YELLOW with rem=02 -> next edge all red, blank=1, way=0; subsequent sequence restarts with way 0 green.
REQ-029 BCD check GREEN_T=12: display sequence 12,11,10,09,...,01, never A-F nibbles.

Source files
------------

// File: rtl/traffic_light_n.sv
// traffic_light_n
// Round-robin N-way traffic-light controller with sensor-based skipping,
// green extension for a lone waiting approach, manual (forced) green and a
// two-digit BCD countdown display.
//
// Ports
//   CLK        clock
//   R          synchronous active-high reset
//   tick       one-second strobe, counted once per cycle it is high
//   traffic    per-approach vehicle-present sensors
//   force_req  per-approach manual green request (one-hot = valid)
//   green      per-approach green lamp
//   yellow     per-approach yellow lamp
//   red        per-approach red lamp
//   way        index of the approach being served
//   bcd_tens   countdown tens digit (0 while blanked)
//   bcd_ones   countdown ones digit (0 while blanked)
//   blank      display off
//
// The manual-request port is named force_req because "force" is a reserved
// word in SystemVerilog.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_ALLRED | clearance, every approach red, display blank
// S_GREEN  | approach `way` green, counting down GREEN_T (or EXT_T)
// S_YELLOW | approach `way` yellow, counting down YELLOW_T
// S_MANUAL | forced green on the requested approach, ticks ignored

module traffic_light_n #(
   parameter int N_WAYS     = 4,
   parameter int GREEN_T    = 10,
   parameter int YELLOW_T   = 3,
   parameter int ALLRED_T   = 1,
   parameter int EXT_T      = 5,
   parameter int MAX_EXT    = 2,
   parameter int SKIP_EMPTY = 1
) (
   input  logic              CLK,
   input  logic              R,
   input  logic              tick,
   input  logic [N_WAYS-1:0] traffic,
   input  logic [N_WAYS-1:0] force_req,
   output logic [N_WAYS-1:0] green,
   output logic [N_WAYS-1:0] yellow,
   output logic [N_WAYS-1:0] red,
   output logic [2:0]        way,
   output logic [3:0]        bcd_tens,
   output logic [3:0]        bcd_ones,
   output logic              blank
);

   localparam logic [1:0] S_ALLRED = 2'd0;
   localparam logic [1:0] S_GREEN  = 2'd1;
   localparam logic [1:0] S_YELLOW = 2'd2;
   localparam logic [1:0] S_MANUAL = 2'd3;

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_T);
   localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_T);
   localparam logic [7:0] ALLRED_BCD = to_bcd(ALLRED_T);
   localparam logic [7:0] EXT_BCD    = to_bcd(EXT_T);
   localparam logic [3:0] MAX_EXT_C  = 4'(MAX_EXT);
   localparam logic [2:0] LAST_WAY   = 3'(N_WAYS - 1);

   function automatic logic [2:0] inc_way(input logic [2:0] w);
      return (w == LAST_WAY) ? 3'd0 : w + 3'd1;
   endfunction

   // Only called with v > 1, so the tens digit never underflows.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   logic [1:0]        st_q, st_d;
   logic [7:0]        rem_q, rem_d;
   logic [2:0]        way_q, way_d;
   logic [2:0]        nxt_q, nxt_d;
   logic [3:0]        ext_q, ext_d;
   logic [N_WAYS-1:0] green_q, green_d;
   logic [N_WAYS-1:0] yellow_q, yellow_d;
   logic [N_WAYS-1:0] red_q, red_d;
   logic [3:0]        tens_q, tens_d;
   logic [3:0]        ones_q, ones_d;
   logic              blank_q, blank_d;

   logic              force_valid;
   logic [2:0]        force_idx;
   logic [N_WAYS-1:0] way_oh;
   logic [N_WAYS-1:0] way_d_oh;
   logic              lone_traffic;
   logic [2:0]        pick;
   logic              found;
   logic [3:0]        cand;

   always_comb begin
      force_idx = 3'd0;
      for (int i = 0; i < N_WAYS; i++) begin
         if (force_req[i]) force_idx = 3'(i);
      end
      force_valid = $onehot(force_req);
   end

   always_comb begin
      way_oh = '0;
      for (int i = 0; i < N_WAYS; i++) begin
         way_oh[i] = (way_q == 3'(i));
      end
      // extension only when the served approach is the sole one waiting
      lone_traffic = ((traffic & way_oh) != '0) && ((traffic & ~way_oh) == '0);
   end

   // First approach with traffic at or after nxt_q, wrapping round.
   always_comb begin
      pick  = nxt_q;
      found = 1'b0;
      cand  = 4'd0;
      if (SKIP_EMPTY != 0) begin
         for (int off = 0; off < N_WAYS; off++) begin
            cand = {1'b0, nxt_q} + 4'(off);
            if (cand >= 4'(N_WAYS)) cand = cand - 4'(N_WAYS);
            for (int j = 0; j < N_WAYS; j++) begin
               if (!found && (cand == 4'(j)) && traffic[j]) begin
                  found = 1'b1;
                  pick  = 3'(j);
               end
            end
         end
      end
   end

   always_comb begin
      st_d  = st_q;
      rem_d = rem_q;
      way_d = way_q;
      nxt_d = nxt_q;
      ext_d = ext_q;
      if (force_valid) begin
         st_d  = S_MANUAL;
         way_d = force_idx;
      end else if (st_q == S_MANUAL) begin
         st_d  = S_ALLRED;
         rem_d = ALLRED_BCD;
         nxt_d = inc_way(way_q);
      end else if (tick) begin
         if (rem_q != 8'h01) begin
            rem_d = bcd_dec(rem_q);
         end else begin
            case (st_q)
               S_ALLRED: begin
                  st_d  = S_GREEN;
                  way_d = pick;
                  rem_d = GREEN_BCD;
                  ext_d = 4'd0;
               end
               S_GREEN: begin
                  if (lone_traffic && (ext_q < MAX_EXT_C)) begin
                     rem_d = EXT_BCD;
                     ext_d = ext_q + 4'd1;
                  end else begin
                     st_d  = S_YELLOW;
                     rem_d = YELLOW_BCD;
                  end
               end
               S_YELLOW: begin
                  st_d  = S_ALLRED;
                  rem_d = ALLRED_BCD;
                  nxt_d = inc_way(way_q);
               end
               default: ;
            endcase
         end
      end
   end

   // Lamp and display values are derived from the next state so that the
   // registered outputs line up with the registered state.
   always_comb begin
      way_d_oh = '0;
      for (int i = 0; i < N_WAYS; i++) begin
         way_d_oh[i] = (way_d == 3'(i));
      end
      green_d  = ((st_d == S_GREEN) || (st_d == S_MANUAL)) ? way_d_oh : '0;
      yellow_d = (st_d == S_YELLOW) ? way_d_oh : '0;
      red_d    = ~(green_d | yellow_d);
      blank_d  = (st_d == S_ALLRED) || (st_d == S_MANUAL);
      tens_d   = blank_d ? 4'd0 : rem_d[7:4];
      ones_d   = blank_d ? 4'd0 : rem_d[3:0];
   end

   always_ff @(posedge CLK) begin
      if (R) begin
         st_q     <= S_ALLRED;
         rem_q    <= ALLRED_BCD;
         way_q    <= 3'd0;
         nxt_q    <= 3'd0;
         ext_q    <= 4'd0;
         green_q  <= '0;
         yellow_q <= '0;
         red_q    <= '1;
         tens_q   <= 4'd0;
         ones_q   <= 4'd0;
         blank_q  <= 1'b1;
      end else begin
         st_q     <= st_d;
         rem_q    <= rem_d;
         way_q    <= way_d;
         nxt_q    <= nxt_d;
         ext_q    <= ext_d;
         green_q  <= green_d;
         yellow_q <= yellow_d;
         red_q    <= red_d;
         tens_q   <= tens_d;
         ones_q   <= ones_d;
         blank_q  <= blank_d;
      end
   end

   assign green    = green_q;
   assign yellow   = yellow_q;
   assign red      = red_q;
   assign way      = way_q;
   assign bcd_tens = tens_q;
   assign bcd_ones = ones_q;
   assign blank    = blank_q;

endmodule

// File: tb/tb_traffic_light_n.sv
module tb_traffic_light_n;

   localparam int N  = 4;
   localparam int G  = 10;
   localparam int Y  = 3;
   localparam int AR = 1;
   localparam int EX = 5;
   localparam int MX = 2;

   localparam int P_AR  = 0;
   localparam int P_G   = 1;
   localparam int P_Y   = 2;
   localparam int P_MAN = 3;

   logic         CLK;
   logic         R;
   logic         tick;
   logic [N-1:0] traffic;
   logic [N-1:0] force_req;
   logic [N-1:0] green, yellow, red;
   logic [2:0]   way;
   logic [3:0]   bcd_tens, bcd_ones;
   logic         blank;

   logic [N-1:0] g12, y12, r12;
   logic [2:0]   w12;
   logic [3:0]   t12, o12;
   logic         b12;

   traffic_light_n #(
      .N_WAYS(N), .GREEN_T(G), .YELLOW_T(Y), .ALLRED_T(AR),
      .EXT_T(EX), .MAX_EXT(MX), .SKIP_EMPTY(1)
   ) dut (
      .CLK(CLK), .R(R), .tick(tick), .traffic(traffic), .force_req(force_req),
      .green(green), .yellow(yellow), .red(red), .way(way),
      .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .blank(blank)
   );

   traffic_light_n #(
      .N_WAYS(N), .GREEN_T(12), .YELLOW_T(Y), .ALLRED_T(AR),
      .EXT_T(EX), .MAX_EXT(MX), .SKIP_EMPTY(1)
   ) dut12 (
      .CLK(CLK), .R(R), .tick(tick), .traffic(traffic), .force_req(force_req),
      .green(g12), .yellow(y12), .red(r12), .way(w12),
      .bcd_tens(t12), .bcd_ones(o12), .blank(b12)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_checks = 0;
   int n_pass   = 0;
   int tick_period = 0;
   int tcnt = 0;
   int tick_count = 0;

   int m_phase, m_rem, m_way, m_nxt, m_ext;

   logic       rec12;
   logic [7:0] last12;
   logic [7:0] seq12[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_update();
      int fi;
      int t;
      int w;
      logic [N-1:0] onew;
      if (R) begin
         m_phase = P_AR; m_rem = AR; m_way = 0; m_nxt = 0; m_ext = 0;
         return;
      end
      if ($countones(force_req) == 1) begin
         fi = 0;
         for (int i = 0; i < N; i++) if (force_req[i]) fi = i;
         m_phase = P_MAN;
         m_way = fi;
      end else if (m_phase == P_MAN) begin
         m_phase = P_AR; m_rem = AR; m_nxt = (m_way + 1) % N;
      end else if (tick) begin
         if (m_rem > 1) begin
            m_rem--;
         end else if (m_phase == P_AR) begin
            t = m_nxt;
            for (int k = 0; k < N; k++) begin
               w = (m_nxt + k) % N;
               if (traffic[w]) begin
                  t = w;
                  break;
               end
            end
            m_way = t; m_phase = P_G; m_rem = G; m_ext = 0;
         end else if (m_phase == P_G) begin
            onew = '0;
            onew[m_way] = 1'b1;
            if (traffic[m_way] && ((traffic & ~onew) == '0) && m_ext < MX) begin
               m_rem = EX; m_ext++;
            end else begin
               m_phase = P_Y; m_rem = Y;
            end
         end else if (m_phase == P_Y) begin
            m_phase = P_AR; m_rem = AR; m_nxt = (m_way + 1) % N;
         end
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] eg, ey, er, oh;
      logic [3:0]   et, eo;
      logic         eb;
      oh = '0;
      oh[m_way] = 1'b1;
      eg = (m_phase == P_G || m_phase == P_MAN) ? oh : '0;
      ey = (m_phase == P_Y) ? oh : '0;
      er = ~(eg | ey);
      eb = (m_phase == P_AR || m_phase == P_MAN);
      et = eb ? 4'd0 : 4'(m_rem / 10);
      eo = eb ? 4'd0 : 4'(m_rem % 10);
      check("outputs_g_y_r_way_tens_ones_blank",
            {green, yellow, red, way, bcd_tens, bcd_ones, blank},
            {eg, ey, er, 3'(m_way), et, eo, eb});
      check("bcd12_digits_in_range", {(t12 <= 4'd9), (o12 <= 4'd9)}, 2'b11);
   endtask

   task automatic step();
      if (tick_period != 0) begin
         tick = (tcnt == tick_period - 1);
         tcnt = (tcnt + 1) % tick_period;
      end else begin
         tick = 1'b0;
      end
      @(posedge CLK);
      model_update();
      if (tick && !R) tick_count++;
      @(negedge CLK);
      compare_all();
      if (rec12) begin
         if (g12[0] && !b12 && ({t12, o12} != last12)) begin
            seq12.push_back({t12, o12});
            last12 = {t12, o12};
         end
         if (y12 != '0) rec12 = 1'b0;
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      R = 1'b1;
      step();
      R = 1'b0;
      tcnt = 0;
   endtask

   function automatic logic cond(input int sel, input logic [7:0] val);
      case (sel)
         0: return green == val[N-1:0];
         1: return yellow == val[N-1:0];
         2: return {bcd_tens, bcd_ones} == val;
         default: return green != '0;
      endcase
   endfunction

   // sel: 0 green==val, 1 yellow==val, 2 display==val, 3 any green
   task automatic wait_out(input int sel, input logic [7:0] val, input int budget, input string name);
      int n;
      n = 0;
      while (!cond(sel, val) && n < budget) begin
         step();
         n++;
      end
      check({"wait_", name}, cond(sel, val), 1'b1);
   endtask

   task automatic wait_ticks(input int target, input int budget);
      int n;
      n = 0;
      while (tick_count < target && n < budget) begin
         step();
         n++;
      end
      check("wait_tick_count", 64'(tick_count), 64'(target));
   endtask

   initial begin
      int t0;
      logic [N-1:0] prev;
      logic [N-1:0] expm;
      logic [7:0]   ev;

      R = 1'b1; tick = 1'b0; traffic = '0; force_req = '0;
      rec12 = 1'b0; last12 = 8'hFF;
      m_phase = P_AR; m_rem = AR; m_way = 0; m_nxt = 0; m_ext = 0;

      // full round robin, all approaches busy
      traffic = 4'b1111;
      do_reset();
      check("reset_red",   red, 4'b1111);
      check("reset_green", green, 4'b0000);
      check("reset_blank", {blank, bcd_tens, bcd_ones, way}, {1'b1, 4'd0, 4'd0, 3'd0});
      rec12 = 1'b1;
      tick_period = 5;
      wait_out(3, 8'h00, 40, "first_green");
      check("first_green_way0", green, 4'b0001);
      check("first_green_disp", {bcd_tens, bcd_ones}, 8'h10);
      t0 = tick_count;
      wait_out(1, 8'h01, 100, "yellow0");
      check("yellow0_disp", {bcd_tens, bcd_ones}, 8'h03);
      check("green_len_10", 64'(tick_count - t0), 64'd10);
      wait_out(0, 8'h02, 40, "green1");
      check("green1_disp", {bcd_tens, bcd_ones}, 8'h10);
      wait_out(0, 8'h04, 100, "green2");
      wait_out(0, 8'h08, 100, "green3");
      wait_out(0, 8'h01, 100, "green0_again");
      check("full_cycle_56", 64'(tick_count - t0), 64'd56);
      check("seq12_len", 64'(seq12.size()), 64'd12);
      for (int k = 0; k < 12 && k < seq12.size(); k++) begin
         ev = {4'((12 - k) / 10), 4'((12 - k) % 10)};
         check("seq12_value", seq12[k], ev);
      end
      rec12 = 1'b0;

      // lone traffic on way 0 earns two extensions
      traffic = 4'b0001;
      do_reset();
      wait_out(3, 8'h00, 40, "ext_green");
      check("ext_green_way0", green, 4'b0001);
      t0 = tick_count;
      wait_ticks(t0 + 10, 100);
      check("ext1_reload_05", {green, bcd_tens, bcd_ones}, {4'b0001, 8'h05});
      wait_ticks(t0 + 15, 100);
      check("ext2_reload_05", {green, bcd_tens, bcd_ones}, {4'b0001, 8'h05});
      wait_out(1, 8'h01, 100, "ext_yellow");
      check("ext_total_20", 64'(tick_count - t0), 64'd20);
      wait_out(3, 8'h00, 60, "ext_next_green");
      check("ext_next_way0", green, 4'b0001);

      // skipping empty approaches, then plain round robin
      traffic = 4'b0000;
      do_reset();
      wait_out(0, 8'h01, 40, "skip_green0");
      wait_out(1, 8'h01, 100, "skip_yellow0");
      traffic = 4'b1000;
      wait_out(3, 8'h00, 60, "skip_next");
      check("skip_to_way3", green, 4'b1000);
      traffic = 4'b0000;
      prev = 4'b1000;
      for (int k = 0; k < N; k++) begin
         expm = '0;
         expm[k] = 1'b1;
         wait_out(1, 8'(prev), 100, "rr_yellow");
         wait_out(3, 8'h00, 60, "rr_green");
         check("rr_order", green, expm);
         prev = expm;
      end

      // manual override
      traffic = 4'b1111;
      do_reset();
      wait_out(0, 8'h01, 40, "man_green0");
      steps(8);
      force_req = 4'b0100;
      step();
      check("man_green2", {green, red, blank, way}, {4'b0100, 4'b1011, 1'b1, 3'd2});
      force_req = 4'b0001;
      step();
      check("man_switch_0", {green, blank}, {4'b0001, 1'b1});
      force_req = 4'b0100;
      step();
      check("man_switch_2", green, 4'b0100);
      steps(20);
      check("man_hold_ticks", green, 4'b0100);
      force_req = 4'b1100;
      step();
      check("man_exit_allred", {red, blank}, {4'b1111, 1'b1});
      force_req = 4'b0000;
      wait_out(3, 8'h00, 40, "man_after");
      check("man_after_way3", {green, bcd_tens, bcd_ones}, {4'b1000, 8'h10});

      // reset pulse during yellow
      do_reset();
      wait_out(1, 8'h01, 100, "rst_yellow");
      wait_out(2, 8'h02, 40, "rst_rem02");
      R = 1'b1;
      step();
      R = 1'b0;
      tcnt = 0;
      check("rst_mid_yellow", {red, blank, way, bcd_tens, bcd_ones}, {4'b1111, 1'b1, 3'd0, 8'h00});
      wait_out(3, 8'h00, 40, "rst_restart");
      check("rst_restart_way0", green, 4'b0001);

      // tick held high, force coinciding with ticks and phase ends
      traffic = 4'b0110;
      tick_period = 1;
      do_reset();
      steps(47);
      force_req = 4'b0010;
      step();
      check("force_over_tick", {green, blank}, {4'b0010, 1'b1});
      force_req = 4'b0000;
      step();
      check("force_release", red, 4'b1111);
      steps(40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
